pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage RISC-V pipeline. It watches ID operands, the EX

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/hazard_detect.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encoding for the pipeline hazard controller
package pipeline_ctrl_pkg;

    localparam int HZ_STATE_W = 2;

    // RUN: normal flow; MEM_WAIT: data memory holding MEM; FAULT: memory timed out
    typedef enum logic [HZ_STATE_W-1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
// Ports:
//   ex_mem_read_i     EX instr is a load
//   ex_rd_i           EX destination register
//   id_rs1_i/id_rs2_i ID source registers
//   id_use_rs1_i/2_i  ID instr actually reads that source
//   load_use_o        ID instr needs a value the EX load has not produced yet
module hazard_detect #(
    parameter int REG_NUM_BITWIDTH = 5
) (
    input  logic                        ex_mem_read_i,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_rd_i,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs1_i,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs2_i,
    input  logic                        id_use_rs1_i,
    input  logic                        id_use_rs2_i,
    output logic                        load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencing for the 5-stage pipeline
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1/id_rs2/id_useRs1/2     ID operand usage
//   ex_memRead/ex_regToWrite      EX load and its destination
//   ex_branchTaken                EX branch/jump resolved taken
//   mem_memAccess/dmem_ready      MEM data-memory handshake
//   pc_stall..memwb_bubble        combinational pipeline controls
//   mem_timeout                   sticky fault indication
//   stall_cycles                  saturating count of PC-stall cycles
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_NUM_BITWIDTH   = 5,
    parameter int MAX_MEM_WAIT       = 16,
    parameter int WAIT_CNT_BITWIDTH  = 5,
    parameter int STALL_CNT_BITWIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REG_NUM_BITWIDTH-1:0]   id_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0]   id_rs2,
    input  logic                          id_useRs1,
    input  logic                          id_useRs2,
    input  logic                          ex_memRead,
    input  logic [REG_NUM_BITWIDTH-1:0]   ex_regToWrite,
    input  logic                          ex_branchTaken,
    input  logic                          mem_memAccess,
    input  logic                          dmem_ready,
    output logic                          pc_stall,
    output logic                          ifid_stall,
    output logic                          ifid_flush,
    output logic                          idex_stall,
    output logic                          idex_flush,
    output logic                          exmem_stall,
    output logic                          memwb_bubble,
    output logic                          mem_timeout,
    output logic [STALL_CNT_BITWIDTH-1:0] stall_cycles
);

    localparam logic [WAIT_CNT_BITWIDTH-1:0]  WAIT_ONE  = {{(WAIT_CNT_BITWIDTH-1){1'b0}}, 1'b1};
    localparam logic [WAIT_CNT_BITWIDTH-1:0]  WAIT_LAST = WAIT_CNT_BITWIDTH'(MAX_MEM_WAIT - 1);
    localparam logic [STALL_CNT_BITWIDTH-1:0] STALL_ONE = {{(STALL_CNT_BITWIDTH-1){1'b0}}, 1'b1};

    hz_state_e                     state_q, state_d;
    logic [WAIT_CNT_BITWIDTH-1:0]  wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_BITWIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mem_wait;

    hazard_detect #(
        .REG_NUM_BITWIDTH(REG_NUM_BITWIDTH)
    ) u_hazard_detect (
        .ex_mem_read_i (ex_memRead),
        .ex_rd_i       (ex_regToWrite),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_use_rs1_i  (id_useRs1),
        .id_use_rs2_i  (id_useRs2),
        .load_use_o    (load_use)
    );

    // Once faulted the handshake no longer matters; FAULT owns the outputs
    assign mem_wait = mem_memAccess && !dmem_ready && (state_q != FAULT);

    // Control outputs: zero-latency, priority FAULT > mem_wait > branch > load_use
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        exmem_stall  = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst) begin
            if ((state_q == FAULT) || mem_wait) begin
                // Freeze everything upstream of MEM; a taken branch in EX is
                // held in place and resolves once the access completes
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                idex_stall   = 1'b1;
                exmem_stall  = 1'b1;
                memwb_bubble = 1'b1;
            end else if (ex_branchTaken) begin
                // ID instr is squashed, so any load-use it carries is moot
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    assign mem_timeout  = !rst && (state_q == FAULT);
    assign stall_cycles = rst ? '0 : stall_cnt_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                // Covers both completion (ready) and abort (access dropped)
                if (!mem_wait) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int RNB = 5;
    localparam int SCB = 4;

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble, mem_timeout}
    localparam logic [7:0] V_NONE = 8'b0000_0000;
    localparam logic [7:0] V_LU   = 8'b1100_1000;
    localparam logic [7:0] V_BR   = 8'b0010_1000;
    localparam logic [7:0] V_FRZ  = 8'b1101_0110;
    localparam logic [7:0] V_FLT  = 8'b1101_0111;

    typedef struct packed {
        logic [RNB-1:0] rs1;
        logic [RNB-1:0] rs2;
        logic           use1;
        logic           use2;
        logic           mrd;
        logic [RNB-1:0] rd;
        logic           br;
        logic           acc;
        logic           rdy;
    } stim_t;

    typedef struct {
        logic [7:0]     v;
        logic [SCB-1:0] sc;
        string          name;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [RNB-1:0] id_rs1 = '0, id_rs2 = '0, ex_regToWrite = '0;
    logic           id_useRs1 = 1'b0, id_useRs2 = 1'b0, ex_memRead = 1'b0;
    logic           ex_branchTaken = 1'b0, mem_memAccess = 1'b0, dmem_ready = 1'b0;
    logic           pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic           exmem_stall, memwb_bubble, mem_timeout;
    logic [SCB-1:0] stall_cycles;
    logic [7:0]     obs;

    exp_t           exp_q[$];
    exp_t           e;
    logic [SCB-1:0] sc_exp = '0;
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    assign obs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                  exmem_stall, memwb_bubble, mem_timeout};

    pipeline_hazard_ctrl #(
        .REG_NUM_BITWIDTH  (RNB),
        .MAX_MEM_WAIT      (4),
        .WAIT_CNT_BITWIDTH (5),
        .STALL_CNT_BITWIDTH(SCB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_useRs1     (id_useRs1),
        .id_useRs2     (id_useRs2),
        .ex_memRead    (ex_memRead),
        .ex_regToWrite (ex_regToWrite),
        .ex_branchTaken(ex_branchTaken),
        .mem_memAccess (mem_memAccess),
        .dmem_ready    (dmem_ready),
        .pc_stall      (pc_stall),
        .ifid_stall    (ifid_stall),
        .ifid_flush    (ifid_flush),
        .idex_stall    (idex_stall),
        .idex_flush    (idex_flush),
        .exmem_stall   (exmem_stall),
        .memwb_bubble  (memwb_bubble),
        .mem_timeout   (mem_timeout),
        .stall_cycles  (stall_cycles)
    );

    function automatic stim_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                                 input bit mrd, input int rd, input bit br, input bit acc,
                                 input bit rdy);
        stim_t s;
        s.rs1 = RNB'(rs1); s.rs2 = RNB'(rs2); s.use1 = u1; s.use2 = u2;
        s.mrd = mrd; s.rd = RNB'(rd); s.br = br; s.acc = acc; s.rdy = rdy;
        return s;
    endfunction

    // Drive one cycle of stimulus and queue what the spec says must appear
    task automatic drive(input stim_t s, input logic [7:0] v, input string nm);
        exp_t x;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_useRs1 = s.use1; id_useRs2 = s.use2;
        ex_memRead = s.mrd; ex_regToWrite = s.rd; ex_branchTaken = s.br;
        mem_memAccess = s.acc; dmem_ready = s.rdy;
        x.v = v; x.sc = sc_exp; x.name = nm;
        exp_q.push_back(x);
        if (v[7] && (sc_exp != '1)) sc_exp = sc_exp + 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, V_NONE, "rst");
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        sc_exp = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        // Inputs that would otherwise freeze and stall must be ignored under reset
        drive(mk(5, 5, 1, 1, 1, 5, 1, 1, 0), V_NONE, "reset_active");
        sc_exp = '0;
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v || stall_cycles !== e.sc) begin
            errors++;
            $display("FAIL %s: ctrl=%b stall_cycles=%0d expected ctrl=%b stall_cycles=%0d",
                     e.name, obs, stall_cycles, e.v, e.sc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive('0, V_NONE, "reset_release");
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v || stall_cycles !== e.sc) begin
            errors++;
            $display("FAIL %s: ctrl=%b stall_cycles=%0d expected ctrl=%b stall_cycles=%0d",
                     e.name, obs, stall_cycles, e.v, e.sc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        stim_t      t[4];
        logic [7:0] v[4];
        do_reset();
        t[0] = mk(0, 5, 0, 1, 1, 5, 0, 0, 0); v[0] = V_LU;
        t[1] = '0;                            v[1] = V_NONE;
        t[2] = mk(9, 0, 1, 0, 1, 9, 0, 0, 0); v[2] = V_LU;
        t[3] = '0;                            v[3] = V_NONE;
        for (int i = 0; i < 4; i++) begin
            drive(t[i], v[i], $sformatf("load_use_%0d", i));
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v || stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL %s: ctrl=%b stall_cycles=%0d expected ctrl=%b stall_cycles=%0d",
                         e.name, obs, stall_cycles, e.v, e.sc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0_unused();
        stim_t t[4];
        do_reset();
        t[0] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0);
        t[1] = mk(7, 3, 0, 1, 1, 7, 0, 0, 0);
        t[2] = mk(3, 7, 1, 0, 1, 7, 0, 0, 0);
        t[3] = mk(7, 7, 1, 1, 0, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(t[i], V_NONE, $sformatf("x0_unused_%0d", i));
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v || stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL %s: ctrl=%b stall_cycles=%0d expected ctrl=%b stall_cycles=%0d",
                         e.name, obs, stall_cycles, e.v, e.sc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_load_use();
        stim_t      t[3];
        logic [7:0] v[3];
        do_reset();
        t[0] = mk(0, 5, 0, 1, 1, 5, 1, 0, 0); v[0] = V_BR;
        t[1] = mk(2, 0, 0, 0, 0, 0, 1, 0, 0); v[1] = V_BR;
        t[2] = '0;                            v[2] = V_NONE;
        for (int i = 0; i < 3; i++) begin
            drive(t[i], v[i], $sformatf("branch_lu_%0d", i));
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v || stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL %s: ctrl=%b stall_cycles=%0d expected ctrl=%b stall_cycles=%0d",
                         e.name, obs, stall_cycles, e.v, e.sc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t      t[5];
        logic [7:0] v[5];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            t[i] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); v[i] = V_FRZ;
        end
        t[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1); v[3] = V_NONE;
        t[4] = '0;                            v[4] = V_NONE;
        for (int i = 0; i < 5; i++) begin
            drive(t[i], v[i], $sformatf("mem_wait_%0d", i));
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v || stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL %s: ctrl=%b stall_cycles=%0d expected ctrl=%b stall_cycles=%0d",
                         e.name, obs, stall_cycles, e.v, e.sc);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cycles !== 4'd3) begin
            errors++;
            $display("FAIL mem_wait_count: stall_cycles=%0d expected 3", stall_cycles);
        end
    endtask

    // Branch held across a wait, then abort clearing the wait counter
    task automatic test_wait_branch_abort();
        stim_t      t[11];
        logic [7:0] v[11];
        do_reset();
        t[0]  = mk(0, 5, 0, 1, 1, 5, 1, 1, 0); v[0]  = V_FRZ;
        t[1]  = mk(0, 5, 0, 1, 1, 5, 1, 1, 0); v[1]  = V_FRZ;
        t[2]  = mk(0, 5, 0, 1, 1, 5, 1, 1, 1); v[2]  = V_BR;
        t[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); v[3]  = V_FRZ;
        t[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); v[4]  = V_FRZ;
        t[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); v[5]  = V_FRZ;
        t[6]  = '0;                             v[6]  = V_NONE;
        t[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); v[7]  = V_FRZ;
        t[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); v[8]  = V_FRZ;
        t[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); v[9]  = V_FRZ;
        t[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1); v[10] = V_NONE;
        for (int i = 0; i < 11; i++) begin
            drive(t[i], v[i], $sformatf("wait_branch_abort_%0d", i));
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v || stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL %s: ctrl=%b stall_cycles=%0d expected ctrl=%b stall_cycles=%0d",
                         e.name, obs, stall_cycles, e.v, e.sc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t      t[11];
        logic [7:0] v[11];
        bit         r[11];
        do_reset();
        for (int i = 0; i < 11; i++) begin
            t[i] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); r[i] = 1'b0;
            v[i] = (i < 4) ? V_FRZ : V_FLT;
        end
        t[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        t[8]  = '0;
        t[9]  = '0; v[9]  = V_NONE; r[9] = 1'b1;
        t[10] = '0; v[10] = V_NONE;
        for (int i = 0; i < 11; i++) begin
            rst = r[i];
            if (r[i]) sc_exp = '0;
            drive(t[i], v[i], $sformatf("timeout_%0d", i));
            if (r[i]) sc_exp = '0;
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v || stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL %s: ctrl=%b stall_cycles=%0d expected ctrl=%b stall_cycles=%0d",
                         e.name, obs, stall_cycles, e.v, e.sc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), (i < 4) ? V_FRZ : V_FLT,
                  $sformatf("saturation_%0d", i));
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v || stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL %s: ctrl=%b stall_cycles=%0d expected ctrl=%b stall_cycles=%0d",
                         e.name, obs, stall_cycles, e.v, e.sc);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cycles !== 4'd15) begin
            errors++;
            $display("FAIL saturation_final: stall_cycles=%0d expected 15", stall_cycles);
        end
    endtask

    task automatic test_back_to_back();
        stim_t      t[5];
        logic [7:0] v[5];
        do_reset();
        t[0] = mk(4, 0, 1, 0, 1, 4, 0, 0, 0);  v[0] = V_LU;
        t[1] = mk(0, 6, 0, 1, 1, 6, 0, 0, 0);  v[1] = V_LU;
        t[2] = mk(8, 0, 1, 0, 1, 8, 1, 0, 0);  v[2] = V_BR;
        t[3] = mk(31, 31, 1, 1, 1, 31, 0, 0, 0); v[3] = V_LU;
        t[4] = '0;                             v[4] = V_NONE;
        for (int i = 0; i < 5; i++) begin
            drive(t[i], v[i], $sformatf("back_to_back_%0d", i));
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v || stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL %s: ctrl=%b stall_cycles=%0d expected ctrl=%b stall_cycles=%0d",
                         e.name, obs, stall_cycles, e.v, e.sc);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_unused();
        test_branch_load_use();
        test_mem_wait();
        test_wait_branch_abort();
        test_timeout();
        test_saturation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
